// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a pointer-addressed 8-bit register file; no clock stretching.
// Optional build macro: I2C_SLV_FILTER_EN adds a 3-sample glitch filter on SCL/SDA.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         PTR_W      = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             sda_o,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_data,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             addressed,
  output logic [3:0]       state_dbg
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  localparam int NREG = 2 ** PTR_W;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  state_t           state;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_f, sda_f, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]       bit_cnt;
  logic [7:0]       sh, rd_sh;
  logic             rw;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NREG];

  assign sda_o     = 1'b0;
  assign host_data = regs[host_addr];
  assign state_dbg = state;

  // Synchronisers reset to 1 so the idle bus produces no spurious edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_SLV_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      if (scl_hist == {2{scl_sync[1]}}) scl_f <= scl_sync[1];
      if (sda_hist == {2{sda_sync[1]}}) sda_f <= sda_sync[1];
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  // wr_stb is a one-cycle valid with no ready: wr_addr/wr_data mean something only while it is high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      rd_sh     <= '0;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      addressed <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WR: begin
            if (scl_rise) begin
              sh      <= {sh[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (state == WR && bit_cnt == 4'd7) begin
                regs[ptr] <= {sh[6:0], sda_f};
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= {sh[6:0], sda_f};
                ptr       <= ptr + PTR_ONE;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (sh[7:1] == SLAVE_ADDR) begin
                  sda_oe    <= 1'b1;
                  addressed <= 1'b1;
                  rw        <= sh[0];
                  state     <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end else if (state == PTR) begin
                ptr    <= sh[PTR_W-1:0];
                sda_oe <= 1'b1;
                state  <= PTR_ACK;
              end else begin
                sda_oe <= 1'b1;
                state  <= WR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                rd_sh  <= {regs[ptr][6:0], 1'b0};
                sda_oe <= ~regs[ptr][7];
                state  <= RD;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end
          PTR_ACK, WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WR;
            end
          end
          RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + PTR_ONE;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~rd_sh[7];
                rd_sh  <= {rd_sh[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            // Next byte is latched here, so later writes cannot alter it mid-flight.
            if (scl_rise && sda_f) begin
              state <= IGNORE;
            end else if (scl_fall) begin
              rd_sh   <= {regs[ptr][6:0], 1'b0};
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= '0;
              state   <= RD;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file model and write scoreboard.
module tb_i2c_slave_regfile;
  localparam int         Q     = 8;
  localparam logic [6:0] SADDR = 7'h50;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       scl       = 1'b1;
  logic       sda_m     = 1'b1;
  logic [2:0] host_addr = 3'd0;
  logic       sda_line;
  logic       sda_oe, sda_o, wr_stb, addressed;
  logic [2:0] wr_addr;
  logic [7:0] host_data, wr_data;
  logic [3:0] state_dbg;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_oe ? (sda_m & sda_o) : sda_m;

  i2c_slave_regfile #(.SLAVE_ADDR(SADDR), .PTR_W(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .sda_o    (sda_o),
    .host_addr(host_addr),
    .host_data(host_data),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .addressed(addressed),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  m_regs[8];
  logic [2:0]  m_ptr;
  bit          oe_seen;

  always @(negedge clk) begin
    if (wr_stb) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wq();
    scl   = 1'b1; wq(2);
    scl   = 1'b0; wq();
  endtask

  task automatic write_bit_glitch();
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b0; repeat (2) @(negedge clk);
    sda_m = 1'b1; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    b     = sda_line; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic check_writes(input string tag);
    logic [10:0] o, e;
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_wr"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 8; a++) begin
      host_addr = 3'(a);
      #1;
      check($sformatf("%s_reg%0d", tag, a), 32'(host_data), 32'(m_regs[a]));
    end
  endtask

  // Write transfer: address byte then every byte of tx_q, then STOP.
  task automatic do_write(input logic [7:0] adr, input string tag);
    logic a;
    bit   match;
    match = (adr[7:1] == SADDR) && !adr[0];
    bus_start();
    write_byte(adr, a);
    check({tag, "_aack"}, 32'(a), 32'(!match));
    check({tag, "_addressed"}, 32'(addressed), 32'(match));
    for (int i = 0; i < tx_q.size(); i++) begin
      write_byte(tx_q[i], a);
      check($sformatf("%s_ack%0d", tag, i), 32'(a), 32'(!match));
      if (match) begin
        if (i == 0) begin
          m_ptr = 3'(tx_q[i] % 8);
        end else begin
          m_regs[m_ptr] = tx_q[i];
          exp_q.push_back({m_ptr, tx_q[i]});
          m_ptr = m_ptr + 3'd1;
        end
      end
    end
    bus_stop();
    wq();
    check({tag, "_released"}, 32'(addressed), 32'd0);
    check_writes(tag);
    check_regs(tag);
  endtask

  // Read transfer, optionally preceded by a pointer write and repeated START.
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
    logic       a;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte({SADDR, 1'b0}, a);
      check({tag, "_waack"}, 32'(a), 32'd0);
      write_byte(p, a);
      check({tag, "_pack"}, 32'(a), 32'd0);
      m_ptr = 3'(p % 8);
      bus_start();
    end
    write_byte({SADDR, 1'b1}, a);
    check({tag, "_raack"}, 32'(a), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      check($sformatf("%s_rd%0d", tag, i), 32'(d), 32'(m_regs[m_ptr]));
      m_ptr = m_ptr + 3'd1;
    end
    bus_stop();
    wq();
    check({tag, "_released"}, 32'(addressed), 32'd0);
    check_writes(tag);
  endtask

  initial begin
    logic       a;
    logic [7:0] b8;
    logic [6:0] na;

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr   = 3'd0;
    oe_seen = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_addressed", 32'(addressed), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_stb", 32'(wr_stb), 32'd0);
    check_regs("rst");

    // Reset asserted while the target is driving an address ACK.
    tx_q = {8'h05, 8'h77};
    do_write(8'hA0, "pre_rst");
    bus_start();
    b8 = 8'hA0;
    for (int i = 7; i >= 0; i--) write_bit(b8[i]);
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    check("mid_ack_oe", 32'(sda_oe), 32'd1);
    check("mid_ack_addressed", 32'(addressed), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_addressed", 32'(addressed), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    scl = 1'b0; wq();
    bus_stop();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 3'd0;
    obs_q.delete();
    check_regs("mid_rst");

    tx_q = {8'h02, 8'h11, 8'h22};
    do_write(8'hA0, "wr2");

    do_read(1'b1, 8'h03, 2, "rd3");

    oe_seen = 1'b0;
    tx_q = {8'h01, 8'h5A};
    do_write(8'hA2, "nomatch");
    check("nomatch_oe", 32'(oe_seen), 32'd0);

    tx_q = {8'h07, 8'hAA, 8'hBB};
    do_write(8'hA0, "wrap");
    tx_q = {8'hF9, 8'h5C};
    do_write(8'hA0, "badptr");

    // STOP after half a data byte: pointer is taken, nothing written.
    bus_start();
    write_byte(8'hA0, a);
    check("part_aack", 32'(a), 32'd0);
    write_byte(8'h04, a);
    check("part_pack", 32'(a), 32'd0);
    m_ptr = 3'd4;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    wq();
    check("part_state", 32'(state_dbg), 32'd0);
    check("part_addressed", 32'(addressed), 32'd0);
    check_writes("part");
    check_regs("part");

    // Repeated START mid-byte aborts the pending byte.
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h06, a);
    m_ptr = 3'd6;
    for (int i = 0; i < 5; i++) write_bit(1'b0);
    tx_q = {8'h01, 8'h9C};
    do_write(8'hA0, "sr_abort");

    do_read(1'b0, 8'h00, 3, "rdcur");

`ifdef I2C_SLV_FILTER_EN
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    m_ptr = 3'd2;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) write_bit_glitch();
      else write_bit(1'b1);
    end
    read_bit(a);
    check("glitch_ack", 32'(a), 32'd0);
    m_regs[2] = 8'hFF;
    exp_q.push_back({3'd2, 8'hFF});
    m_ptr = 3'd3;
    bus_stop();
    wq();
    check_writes("glitch");
    check_regs("glitch");
`endif

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          tx_q.delete();
          tx_q.push_back(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom_range(0, 255)));
          do_write(8'hA0, $sformatf("rw%0d", it));
        end
        1: begin
          na = 7'($urandom_range(0, 127));
          if (na == SADDR) na = 7'h51;
          tx_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
          oe_seen = 1'b0;
          do_write({na, 1'b0}, $sformatf("rn%0d", it));
          check($sformatf("rn%0d_oe", it), 32'(oe_seen), 32'd0);
        end
        default: begin
          do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom_range(1, 3), $sformatf("rr%0d", it));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
